cmos_frame_gen: RTL and testbench

Parametrised CMOS image-sensor frame generator that drives the camera-side bus (vsync, href, 8-bit-style data) of the capture path with synthetic frames of programmable geometry, blanking and pixel pattern. It is the successor to the hand-written sensor stimulus used at system level. It is synthesisable, so it serves two purposes: a simulation source, and an on-chip test source muxed ahead of the capture/SDRAM write path. One frame is produced per start request, or frames are produced back-to-back in continuous mode.

---
 rtl/cmos_frame_gen.sv | 179 +++++++++++++++++
 tb/tb_cmos_frame_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_frame_gen.sv
// Synthetic CMOS sensor frame source: vsync/href/data with programmable geometry, blanking and pattern.
// Optional checksum outputs (frame_sum, sum_valid) exist only when CMOS_FRAME_GEN_SUM_EN is defined.
module cmos_frame_gen #(
  parameter int ROW       = 720,
  parameter int COL       = 1024,
  parameter int BPP       = 2,
  parameter int DW        = 8,
  parameter int HBLANK    = 100,
  parameter int VSYNC_LEN = 101,
  parameter int VBP       = 16,
  parameter int VFP       = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          continuous,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] const_val,
  output logic          cmos_vsyn,
  output logic          cmos_href,
  output logic [DW-1:0] cmos_data,
  output logic          busy,
`ifdef CMOS_FRAME_GEN_SUM_EN
  output logic [15:0]   frame_sum,
  output logic          sum_valid,
`endif
  output logic          frame_done
);
  localparam int LINE = COL * BPP;
  localparam int BW   = $clog2(LINE + 1);
  localparam int LW   = $clog2(ROW + 1);
  localparam int M1   = (VSYNC_LEN > HBLANK) ? VSYNC_LEN : HBLANK;
  localparam int M2   = (VBP > VFP) ? VBP : VFP;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [BW-1:0] B_LAST   = BW'(LINE - 1);
  localparam logic [LW-1:0] L_LAST   = LW'(ROW - 1);
  localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(HBLANK - 1);
  localparam logic [CW-1:0] VBP_LAST = CW'(VBP - 1);
  localparam logic [CW-1:0] VFP_LAST = CW'(VFP - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_HBL, S_ACT, S_VFP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] b;
  logic [LW-1:0] l;
  logic [1:0]    mode_q;
  logic [DW-1:0] const_q;

  logic [BW-1:0] beat_nxt;
  logic [DW-1:0] data_nxt;
  logic          last_nxt;
  logic          enter_vs;
  logic          issue;

  function automatic logic [DW-1:0] pattern(input logic [BW-1:0] bb, input logic [LW-1:0] ll,
                                            input logic [1:0] m, input logic [DW-1:0] cv);
    logic [31:0] bi, li, s;
    bi = 32'(bb);
    li = 32'(ll);
    s  = bi + li;
    case (m)
      2'd0:    pattern = DW'(bi);
      2'd1:    pattern = DW'(s);
      2'd2:    pattern = cv;
      default: pattern = (bi[3] ^ li[3]) ? '1 : '0;
    endcase
  endfunction

  // issue: a data beat goes out on the next cycle; frame_done marks the final cycle of a frame
  always_comb begin
    beat_nxt = (state == S_ACT) ? b + BW'(1) : '0;
    data_nxt = pattern(beat_nxt, l, mode_q, const_q);
    last_nxt = (VFP == 0) && (l == L_LAST) && (beat_nxt == B_LAST);
    enter_vs = frame_done ? continuous : ((state == S_IDLE) && start);
    issue    = !frame_done && (((state == S_HBL) && (cnt == HB_LAST)) ||
                               ((state == S_ACT) && (b != B_LAST)));
  end

  always_ff @(posedge CLK) begin
    if (enter_vs) begin
      mode_q  <= mode;
      const_q <= const_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      b          <= '0;
      l          <= '0;
      cmos_vsyn  <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_data  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (issue) begin
        b          <= beat_nxt;
        cmos_href  <= 1'b1;
        cmos_data  <= data_nxt;
        frame_done <= last_nxt;
      end
      if (enter_vs) begin
        state     <= S_VSYNC;
        cnt       <= '0;
        b         <= '0;
        l         <= '0;
        cmos_vsyn <= 1'b1;
        cmos_href <= 1'b0;
        busy      <= 1'b1;
      end else if (frame_done) begin
        state     <= S_IDLE;
        cmos_href <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_VSYNC:
            if (cnt == VS_LAST) begin
              cnt       <= '0;
              cmos_vsyn <= 1'b0;
              state     <= (VBP > 0) ? S_VBP : S_HBL;
            end else begin
              cnt <= cnt + CW'(1);
            end
          S_VBP:
            if (cnt == VBP_LAST) begin
              cnt   <= '0;
              state <= S_HBL;
            end else begin
              cnt <= cnt + CW'(1);
            end
          S_HBL:
            if (cnt == HB_LAST) begin
              cnt   <= '0;
              state <= S_ACT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          S_ACT:
            if (b == B_LAST) begin
              cmos_href <= 1'b0;
              cnt       <= '0;
              if (l != L_LAST) begin
                l     <= l + LW'(1);
                state <= S_HBL;
              end else begin
                state      <= S_VFP;
                frame_done <= (VFP == 1);
              end
            end
          S_VFP: begin
            cnt        <= cnt + CW'(1);
            frame_done <= ((cnt + CW'(1)) == VFP_LAST);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CMOS_FRAME_GEN_SUM_EN
  // Accumulated at beat issue so the final beat is included when frame_done rises.
  always_ff @(posedge CLK) begin
    if (RST || enter_vs)
      frame_sum <= '0;
    else if (issue)
      frame_sum <= frame_sum + 16'(data_nxt);
  end

  assign sum_valid = frame_done;
`endif

endmodule

// File: tb/tb_cmos_frame_gen.sv
// Bench for cmos_frame_gen: two geometries, vector table, directed corner sequences and random frames.
`timescale 1ns/1ps
module tb_cmos_frame_gen;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] const_val = 8'd0;
  logic       vs1, hr1, bz1, fd1, vs2, hr2, bz2, fd2;
  logic [7:0] d1, d2;
`ifdef CMOS_FRAME_GEN_SUM_EN
  logic [15:0] fs1, fs2;
  logic        sv1, sv2;
`endif

  int passed = 0;
  int total  = 0;
  logic [7:0] last_d [2];

  always #5 CLK = ~CLK;

  cmos_frame_gen #(.ROW(4), .COL(8), .BPP(2), .DW(8), .HBLANK(3), .VSYNC_LEN(5), .VBP(2), .VFP(2)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .continuous(continuous), .mode(mode), .const_val(const_val),
    .cmos_vsyn(vs1), .cmos_href(hr1), .cmos_data(d1), .busy(bz1),
`ifdef CMOS_FRAME_GEN_SUM_EN
    .frame_sum(fs1), .sum_valid(sv1),
`endif
    .frame_done(fd1));

  cmos_frame_gen #(.ROW(9), .COL(16), .BPP(1), .DW(8), .HBLANK(2), .VSYNC_LEN(3), .VBP(0), .VFP(0)) dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .continuous(continuous), .mode(mode), .const_val(const_val),
    .cmos_vsyn(vs2), .cmos_href(hr2), .cmos_data(d2), .busy(bz2),
`ifdef CMOS_FRAME_GEN_SUM_EN
    .frame_sum(fs2), .sum_valid(sv2),
`endif
    .frame_done(fd2));

  typedef struct { int vs; int vbp; int hb; int line; int rows; int vfp; } geo_t;
  typedef struct { int vs; int hr; int fd; int b; int l; } exp_t;
  typedef struct { int vs; int hr; int bz; int fd; int d; int fs; int sv; } obs_t;
  typedef struct { int s; logic [1:0] m; logic [7:0] cv; int l; int b; logic [7:0] exp; } vec_t;

  function automatic geo_t geo(input int s);
    geo_t g;
    if (s == 0) g = '{5, 2, 3, 16, 4, 2};
    else        g = '{3, 0, 2, 16, 9, 0};
    return g;
  endfunction

  function automatic int frame_len(input int s);
    geo_t g;
    g = geo(s);
    return g.vs + g.vbp + g.rows * (g.hb + g.line) + g.vfp;
  endfunction

  function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] cv, input int b, input int l);
    case (m)
      2'd0:    return 8'(b % 256);
      2'd1:    return 8'((b + l) % 256);
      2'd2:    return cv;
      default: return (((b / 8) + (l / 8)) % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Expected bus state at cycle k of a frame (k=1 is the first vsync cycle).
  function automatic exp_t model(input int s, input int k);
    geo_t g;
    exp_t e;
    int t, per;
    g = geo(s);
    per = g.hb + g.line;
    e.vs = (k <= g.vs) ? 1 : 0;
    e.hr = 0;
    e.b = 0;
    e.l = 0;
    e.fd = (k == frame_len(s)) ? 1 : 0;
    t = k - 1 - g.vs - g.vbp;
    if (t >= 0 && t < g.rows * per) begin
      e.l = t / per;
      e.b = (t % per) - g.hb;
      e.hr = (e.b >= 0) ? 1 : 0;
    end
    return e;
  endfunction

  function automatic obs_t observe(input int s);
    obs_t o;
    o.fs = 0;
    o.sv = 0;
    if (s == 0) begin
      o.vs = int'(vs1); o.hr = int'(hr1); o.bz = int'(bz1); o.fd = int'(fd1); o.d = int'(d1);
`ifdef CMOS_FRAME_GEN_SUM_EN
      o.fs = int'(fs1); o.sv = int'(sv1);
`endif
    end else begin
      o.vs = int'(vs2); o.hr = int'(hr2); o.bz = int'(bz2); o.fd = int'(fd2); o.d = int'(d2);
`ifdef CMOS_FRAME_GEN_SUM_EN
      o.fs = int'(fs2); o.sv = int'(sv2);
`endif
    end
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start1 = v;
    else        start2 = v;
  endtask

  task automatic begin_frame(input int s, input logic [1:0] m, input logic [7:0] cv, input logic cont);
    mode = m;
    const_val = cv;
    continuous = cont;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
  endtask

  // Checks every cycle of one frame; halfway through, drives the settings for the frame-end decision.
  task automatic run_frame(input int s, input logic [1:0] m, input logic [7:0] cv, input logic cont_next,
                           input logic [1:0] m_next, input logic [7:0] cv_next, input logic rand_start);
    int len, sum;
    exp_t e;
    obs_t o;
    len = frame_len(s);
    sum = 0;
    for (int k = 1; k <= len; k++) begin
      e = model(s, k);
      o = observe(s);
      if (e.hr == 1) begin
        last_d[s] = pat(m, cv, e.b, e.l);
        sum = (sum + int'(last_d[s])) % 65536;
      end
      check($sformatf("vsyn s%0d k%0d", s, k), o.vs, e.vs);
      check($sformatf("href s%0d k%0d", s, k), o.hr, e.hr);
      check($sformatf("busy s%0d k%0d", s, k), o.bz, 1);
      check($sformatf("frame_done s%0d k%0d", s, k), o.fd, e.fd);
      check($sformatf("data s%0d k%0d", s, k), o.d, int'(last_d[s]));
`ifdef CMOS_FRAME_GEN_SUM_EN
      check($sformatf("sum_valid s%0d k%0d", s, k), o.sv, e.fd);
      if (e.fd == 1) check($sformatf("frame_sum s%0d", s), o.fs, sum);
`endif
      set_start(s, rand_start ? 1'($urandom_range(0, 1)) : 1'b0);
      if (k == len / 2) begin
        continuous = cont_next;
        mode = m_next;
        const_val = cv_next;
      end
      if (k < len) tick();
    end
  endtask

  task automatic finish_idle(input int s);
    obs_t o;
    tick();
    set_start(s, 1'b0);
    o = observe(s);
    check($sformatf("busy_fall s%0d", s), o.bz, 0);
    check($sformatf("idle_vsyn s%0d", s), o.vs, 0);
    check($sformatf("idle_href s%0d", s), o.hr, 0);
    check($sformatf("idle_done s%0d", s), o.fd, 0);
    check($sformatf("idle_data_hold s%0d", s), o.d, int'(last_d[s]));
    repeat (3) begin
      tick();
      o = observe(s);
      check($sformatf("idle_busy s%0d", s), o.bz, 0);
    end
  endtask

  task automatic peek(input vec_t v);
    geo_t g;
    obs_t o;
    int target, n;
    g = geo(v.s);
    target = g.vs + g.vbp + v.l * (g.hb + g.line) + g.hb + v.b + 1;
    begin_frame(v.s, v.m, v.cv, 1'b0);
    for (int k = 1; k < target; k++) tick();
    o = observe(v.s);
    check($sformatf("vec_href s%0d m%0d l%0d b%0d", v.s, v.m, v.l, v.b), o.hr, 1);
    check($sformatf("vec_data s%0d m%0d l%0d b%0d", v.s, v.m, v.l, v.b), o.d, int'(v.exp));
    n = 0;
    while (o.bz == 1 && n < 400) begin
      tick();
      o = observe(v.s);
      n++;
    end
    check($sformatf("vec_frame_end s%0d", v.s), o.bz, 0);
    last_d[v.s] = pat(v.m, v.cv, g.line - 1, g.rows - 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [12];
    obs_t o;
    int k, vs_cnt, first_hr, done_at, saw_done;
    int s, nfr;
    logic [1:0] m, m_n;
    logic [7:0] cv, cv_n;
    logic cn;

    vecs[0]  = '{0, 2'd0, 8'h00, 0, 0,  8'h00};
    vecs[1]  = '{0, 2'd0, 8'h00, 0, 15, 8'h0F};
    vecs[2]  = '{0, 2'd0, 8'h00, 3, 15, 8'h0F};
    vecs[3]  = '{0, 2'd1, 8'h00, 3, 0,  8'h03};
    vecs[4]  = '{0, 2'd1, 8'h00, 3, 15, 8'h12};
    vecs[5]  = '{0, 2'd2, 8'hA5, 1, 7,  8'hA5};
    vecs[6]  = '{1, 2'd3, 8'h00, 0, 7,  8'h00};
    vecs[7]  = '{1, 2'd3, 8'h00, 0, 8,  8'hFF};
    vecs[8]  = '{1, 2'd3, 8'h00, 8, 0,  8'hFF};
    vecs[9]  = '{1, 2'd3, 8'h00, 8, 15, 8'h00};
    vecs[10] = '{0, 2'd3, 8'h00, 0, 8,  8'hFF};
    vecs[11] = '{1, 2'd1, 8'h00, 8, 15, 8'h17};
    last_d[0] = 8'h00;
    last_d[1] = 8'h00;

    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      o = observe(i);
      check($sformatf("rst_vsyn s%0d", i), o.vs, 0);
      check($sformatf("rst_href s%0d", i), o.hr, 0);
      check($sformatf("rst_data s%0d", i), o.d, 0);
      check($sformatf("rst_busy s%0d", i), o.bz, 0);
      check($sformatf("rst_done s%0d", i), o.fd, 0);
    end
    RST = 1'b0;
    tick();

    // Frame timing landmarks, mode 0
    begin_frame(0, 2'd0, 8'h00, 1'b0);
    k = 1; vs_cnt = 0; first_hr = -1; done_at = -1;
    while (done_at < 0 && k <= 200) begin
      if (vs1) vs_cnt++;
      if (hr1 && first_hr < 0) first_hr = k;
      if (fd1) done_at = k;
      if (done_at < 0) begin
        tick();
        k++;
      end
    end
    check("vsync_high_cycles", vs_cnt, 5);
    check("first_href_after_vsync", first_hr - 1, 10);
    check("frame_done_cycle", done_at, 85);
    tick();
    check("busy_falls_after_done", int'(bz1), 0);
    last_d[0] = 8'h0F;
    tick();

    // Vector table
    for (int i = 0; i < 12; i++) begin
      peek(vecs[i]);
      tick();
    end

    // Full-frame model checks on both geometries
    begin_frame(0, 2'd1, 8'h00, 1'b0);
    run_frame(0, 2'd1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    finish_idle(0);
    begin_frame(1, 2'd3, 8'h00, 1'b0);
    run_frame(1, 2'd3, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    finish_idle(1);

    // Continuous for two frames, dropped in the middle of the third; mode re-latched per frame
    begin_frame(0, 2'd0, 8'h00, 1'b1);
    run_frame(0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h00, 1'b0);
    tick();
    run_frame(0, 2'd1, 8'h00, 1'b1, 2'd2, 8'h5A, 1'b0);
    tick();
    run_frame(0, 2'd2, 8'h5A, 1'b0, 2'd3, 8'h00, 1'b0);
    finish_idle(0);

    // Reset in the middle of line 2
    begin_frame(0, 2'd0, 8'h00, 1'b0);
    for (int i = 1; i < 54; i++) tick();
    check("pre_reset_href", int'(hr1), 1);
    RST = 1'b1;
    tick();
    check("mid_rst_vsyn", int'(vs1), 0);
    check("mid_rst_href", int'(hr1), 0);
    check("mid_rst_data", int'(d1), 0);
    check("mid_rst_busy", int'(bz1), 0);
    check("mid_rst_done", int'(fd1), 0);
    RST = 1'b0;
    last_d[0] = 8'h00;
    last_d[1] = 8'h00;
    saw_done = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fd1) saw_done++;
    end
    check("no_done_after_reset", saw_done, 0);
    check("idle_after_reset", int'(bz1), 0);
    begin_frame(0, 2'd1, 8'h00, 1'b0);
    run_frame(0, 2'd1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    finish_idle(0);

    // Random frames with stray start pulses and random continuous runs
    for (int it = 0; it < 6; it++) begin
      s = $urandom_range(0, 1);
      nfr = $urandom_range(1, 3);
      m = 2'($urandom_range(0, 3));
      cv = 8'($urandom_range(0, 255));
      begin_frame(s, m, cv, (nfr > 1) ? 1'b1 : 1'b0);
      for (int f = 0; f < nfr; f++) begin
        cn = (f < nfr - 1) ? 1'b1 : 1'b0;
        m_n = 2'($urandom_range(0, 3));
        cv_n = 8'($urandom_range(0, 255));
        run_frame(s, m, cv, cn, m_n, cv_n, 1'b1);
        if (cn) begin
          tick();
          set_start(s, 1'b0);
          m = m_n;
          cv = cv_n;
        end
      end
      finish_idle(s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
